// File: rtl/apb_requester_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : apb_requester_pkg
//  Description : Shared APB definitions. Holds the transfer FSM encoding and
//                the {psel, penable} phase constants for each bus phase.
//  Revision    : 1.0 - initial release
// ============================================================================
package apb_requester_pkg;

  // Transfer FSM encoding, shared by requester and completer blocks
  typedef logic [1:0] apb_state_t;
  localparam apb_state_t ST_IDLE   = 2'd0;
  localparam apb_state_t ST_SETUP  = 2'd1;
  localparam apb_state_t ST_ACCESS = 2'd2;
  localparam apb_state_t ST_RESP   = 2'd3;

  // APB phase as driven on the bus: {psel, penable}
  typedef logic [1:0] apb_phase_t;
  localparam apb_phase_t PHASE_IDLE   = 2'b00;
  localparam apb_phase_t PHASE_SETUP  = 2'b10;
  localparam apb_phase_t PHASE_ACCESS = 2'b11;

  // Bus phase that belongs to a given FSM state
  function automatic apb_phase_t state_phase(input apb_state_t st);
    apb_phase_t ph;
    case (st)
      ST_SETUP:  ph = PHASE_SETUP;
      ST_ACCESS: ph = PHASE_ACCESS;
      default:   ph = PHASE_IDLE;
    endcase
    return ph;
  endfunction

endpackage
`default_nettype wire

// File: rtl/apb_requester_if.sv
`default_nettype none
// ============================================================================
//  Module      : apb_requester_if
//  Description : Command stream, response stream and APB3 bus of the
//                requester. The master view belongs to the requester; the
//                slave view belongs to whatever feeds commands and models the
//                completer.
//  Revision    : 1.0 - initial release
// ============================================================================
interface apb_requester_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);

  // Command stream
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic                  cmd_write;
  logic [DATA_WIDTH-1:0] cmd_wdata;

  // Response stream
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_slverr;
  logic                  rsp_timeout;

  // APB3 bus
  logic [ADDR_WIDTH-1:0] m_apb_paddr;
  logic                  m_apb_psel;
  logic                  m_apb_penable;
  logic                  m_apb_pwrite;
  logic [DATA_WIDTH-1:0] m_apb_pwdata;
  logic [DATA_WIDTH-1:0] m_apb_prdata;
  logic                  m_apb_pready;
  logic                  m_apb_pslverr;

  modport master (
    input  cmd_valid, cmd_addr, cmd_write, cmd_wdata,
    output cmd_ready,
    output rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout,
    input  rsp_ready,
    output m_apb_paddr, m_apb_psel, m_apb_penable, m_apb_pwrite, m_apb_pwdata,
    input  m_apb_prdata, m_apb_pready, m_apb_pslverr
  );

  modport slave (
    output cmd_valid, cmd_addr, cmd_write, cmd_wdata,
    input  cmd_ready,
    input  rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout,
    output rsp_ready,
    input  m_apb_paddr, m_apb_psel, m_apb_penable, m_apb_pwrite, m_apb_pwdata,
    output m_apb_prdata, m_apb_pready, m_apb_pslverr
  );

endinterface
`default_nettype wire

// File: rtl/apb_requester_watchdog.sv
`default_nettype none
// ============================================================================
//  Module      : apb_requester_watchdog
//  Description : Wait-state counter for the ACCESS phase. Cleared before a
//                transfer, counts cycles while enabled, and flags expiry on
//                the enabled cycle in which the count reaches
//                TIMEOUT_CYCLES-1. TIMEOUT_CYCLES=0 never expires.
//  Revision    : 1.0 - initial release
// ============================================================================
module apb_requester_watchdog #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic clear,
  input  wire logic enable,
  output logic      expire
);

  localparam int              CNT_W     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int              LIMIT_INT = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam logic [CNT_W-1:0] LIMIT    = CNT_W'(LIMIT_INT);
  localparam bit              ENABLED   = (TIMEOUT_CYCLES > 0);

  logic [CNT_W-1:0] count;

  // Count stalled ACCESS cycles; the counter never passes LIMIT because
  // expiry forces the FSM out of ACCESS
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && ENABLED) begin
      count <= count + 1'b1;
    end
  end

  assign expire = ENABLED && enable && (count == LIMIT);

endmodule
`default_nettype wire

// File: rtl/apb_requester.sv
`default_nettype none
// ============================================================================
//  Module      : apb_requester
//  Description : APB3 requester. Turns a valid/ready command stream into
//                single SETUP/ACCESS transfers and returns read data and
//                error status on a valid/ready response stream. A wait-state
//                watchdog aborts transfers to a hung completer.
//  Revision    : 1.0 - initial release
// ============================================================================
module apb_requester
  import apb_requester_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  wire logic       m_apb_aclk,
  input  wire logic       m_apb_areset,
  apb_requester_if.master bus
);

  apb_state_t            state;
  apb_state_t            state_next;
  apb_phase_t            phase_next;

  logic                  cmd_fire;
  logic                  wd_clear;
  logic                  wd_enable;
  logic                  wd_expire;

  logic [ADDR_WIDTH-1:0] paddr,  paddr_next;
  logic                  pwrite, pwrite_next;
  logic [DATA_WIDTH-1:0] pwdata, pwdata_next;
  logic                  psel,   psel_next;
  logic                  penable, penable_next;

  logic                  rsp_valid,   rsp_valid_next;
  logic [DATA_WIDTH-1:0] rsp_rdata,   rsp_rdata_next;
  logic                  rsp_slverr,  rsp_slverr_next;
  logic                  rsp_timeout, rsp_timeout_next;

  assign cmd_fire  = (state == ST_IDLE) && bus.cmd_valid;
  // Counter starts from zero on the first ACCESS cycle
  assign wd_clear  = (state == ST_SETUP);
  assign wd_enable = (state == ST_ACCESS) && !bus.m_apb_pready;

  apb_requester_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (m_apb_aclk),
    .rst    (m_apb_areset),
    .clear  (wd_clear),
    .enable (wd_enable),
    .expire (wd_expire)
  );

  // State register; reset aborts any transfer in flight
  always_ff @(posedge m_apb_aclk or posedge m_apb_areset) begin
    if (m_apb_areset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; pready wins over a same-cycle watchdog expiry
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (bus.cmd_valid) state_next = ST_SETUP;
      ST_SETUP:  state_next = ST_ACCESS;
      ST_ACCESS: if (bus.m_apb_pready || wd_expire) state_next = ST_RESP;
      ST_RESP:   if (bus.rsp_ready) state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // Next values of the registered bus and response outputs
  always_comb begin
    phase_next       = state_phase(state_next);
    psel_next        = phase_next[1];
    penable_next     = phase_next[0];
    paddr_next       = paddr;
    pwrite_next      = pwrite;
    pwdata_next      = pwdata;
    rsp_valid_next   = (state_next == ST_RESP);
    rsp_rdata_next   = rsp_rdata;
    rsp_slverr_next  = rsp_slverr;
    rsp_timeout_next = rsp_timeout;

    // Address/data change only on accept, so they hold through the transfer
    // and keep their last values while the bus is idle
    if (cmd_fire) begin
      paddr_next  = bus.cmd_addr;
      pwrite_next = bus.cmd_write;
      pwdata_next = bus.cmd_wdata;
    end

    if (state == ST_ACCESS) begin
      if (bus.m_apb_pready) begin
        rsp_rdata_next   = pwrite ? '0 : bus.m_apb_prdata;
        rsp_slverr_next  = bus.m_apb_pslverr;
        rsp_timeout_next = 1'b0;
      end else if (wd_expire) begin
        rsp_rdata_next   = '0;
        rsp_slverr_next  = 1'b1;
        rsp_timeout_next = 1'b1;
      end
    end
  end

  // Output registers; every APB output comes straight from a flop
  always_ff @(posedge m_apb_aclk or posedge m_apb_areset) begin
    if (m_apb_areset) begin
      paddr       <= '0;
      pwrite      <= 1'b0;
      pwdata      <= '0;
      psel        <= 1'b0;
      penable     <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_slverr  <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      paddr       <= paddr_next;
      pwrite      <= pwrite_next;
      pwdata      <= pwdata_next;
      psel        <= psel_next;
      penable     <= penable_next;
      rsp_valid   <= rsp_valid_next;
      rsp_rdata   <= rsp_rdata_next;
      rsp_slverr  <= rsp_slverr_next;
      rsp_timeout <= rsp_timeout_next;
    end
  end

  assign bus.cmd_ready     = (state == ST_IDLE);
  assign bus.m_apb_paddr   = paddr;
  assign bus.m_apb_psel    = psel;
  assign bus.m_apb_penable = penable;
  assign bus.m_apb_pwrite  = pwrite;
  assign bus.m_apb_pwdata  = pwdata;
  assign bus.rsp_valid     = rsp_valid;
  assign bus.rsp_rdata     = rsp_rdata;
  assign bus.rsp_slverr    = rsp_slverr;
  assign bus.rsp_timeout   = rsp_timeout;

endmodule
`default_nettype wire

// File: tb/tb_apb_requester.sv
`default_nettype none
// ============================================================================
//  Module      : tb_apb_requester
//  Description : Directed bench for apb_requester with a response scoreboard
//                and a programmable completer model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_apb_requester;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  apb_requester_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  apb_requester #(
    .ADDR_WIDTH     (AW),
    .DATA_WIDTH     (DW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .m_apb_aclk   (clk),
    .m_apb_areset (rst),
    .bus          (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] rdata;
    logic        slverr;
    logic        timeout;
  } exp_t;
  exp_t exp_q[$];

  // Completer model: pready rises after cfg_wait stalled ACCESS cycles
  int          cfg_wait   = 0;
  logic        cfg_hang   = 1'b0;
  logic        cfg_slverr = 1'b0;
  logic [31:0] cfg_prdata = 32'h0;
  int          acc_cnt    = 0;

  always @(posedge clk) begin
    if (bus.m_apb_psel && bus.m_apb_penable && !bus.m_apb_pready) acc_cnt <= acc_cnt + 1;
    else acc_cnt <= 0;
  end

  assign bus.m_apb_pready  = bus.m_apb_psel && bus.m_apb_penable && !cfg_hang && (acc_cnt == cfg_wait);
  assign bus.m_apb_prdata  = cfg_prdata;
  assign bus.m_apb_pslverr = bus.m_apb_pready && cfg_slverr;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic expect_rsp(input logic [31:0] rdata, input logic slverr, input logic timeout);
    exp_t e;
    e.rdata   = rdata;
    e.slverr  = slverr;
    e.timeout = timeout;
    exp_q.push_back(e);
  endtask

  task automatic score_rsp();
    exp_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL rsp_unexpected: got rdata 0x%08h with empty scoreboard", bus.rsp_rdata);
    end else begin
      e = exp_q.pop_front();
      check32("rsp_rdata", bus.rsp_rdata, e.rdata);
      check1("rsp_slverr", bus.rsp_slverr, e.slverr);
      check1("rsp_timeout", bus.rsp_timeout, e.timeout);
    end
  endtask

  // Monitor: score every response handshake
  always @(negedge clk) begin
    if (!rst && bus.rsp_valid && bus.rsp_ready) score_rsp();
  end

  task automatic set_completer(input int wait_cycles, input logic hang, input logic slverr,
                               input logic [31:0] prdata);
    cfg_wait   = wait_cycles;
    cfg_hang   = hang;
    cfg_slverr = slverr;
    cfg_prdata = prdata;
  endtask

  // Present a command; returns 1 time unit into the cycle after the accept
  task automatic issue(input logic [31:0] addr, input logic write, input logic [31:0] wdata);
    int n;
    n = 0;
    bus.cmd_addr  = addr;
    bus.cmd_write = write;
    bus.cmd_wdata = wdata;
    bus.cmd_valid = 1'b1;
    @(negedge clk);
    while (!bus.cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check1("cmd_accept", bus.cmd_ready, 1'b1);
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
  endtask

  // Follow a transfer until rsp_valid, counting penable cycles
  task automatic run_access(input logic [31:0] addr, output int pen, output logic stable,
                            output logic seen);
    pen    = 0;
    stable = 1'b1;
    seen   = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (bus.m_apb_penable) pen++;
      if (bus.m_apb_psel && bus.m_apb_paddr !== addr) stable = 1'b0;
      if (bus.rsp_valid) seen = 1'b1;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check32("scoreboard_drained", exp_q.size(), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #50000;
    $display("FAIL global_timeout: simulation did not finish, got %0d checks", checks);
    $fatal(1, "simulation stuck");
  end

  initial begin
    int   pen;
    logic stable;
    logic seen;
    logic stall_ok;

    bus.cmd_valid = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_write = 1'b0;
    bus.cmd_wdata = '0;
    bus.rsp_ready = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check1("rst_psel", bus.m_apb_psel, 1'b0);
    check1("rst_penable", bus.m_apb_penable, 1'b0);
    check1("rst_pwrite", bus.m_apb_pwrite, 1'b0);
    check32("rst_paddr", bus.m_apb_paddr, 32'h0);
    check32("rst_pwdata", bus.m_apb_pwdata, 32'h0);
    check1("rst_rsp_valid", bus.rsp_valid, 1'b0);
    check32("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
    check1("rst_rsp_slverr", bus.rsp_slverr, 1'b0);
    check1("rst_rsp_timeout", bus.rsp_timeout, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check1("idle_cmd_ready", bus.cmd_ready, 1'b1);
    @(posedge clk);
    #1;

    // Zero-wait write; prdata is nonzero so write data must be masked to 0
    set_completer(0, 1'b0, 1'b0, 32'hFFFF_0000);
    expect_rsp(32'h0, 1'b0, 1'b0);
    issue(32'h0000_0010, 1'b1, 32'hDEAD_BEEF);
    @(negedge clk);
    check1("wr_c1_psel", bus.m_apb_psel, 1'b1);
    check1("wr_c1_penable", bus.m_apb_penable, 1'b0);
    check32("wr_c1_paddr", bus.m_apb_paddr, 32'h0000_0010);
    check1("wr_c1_pwrite", bus.m_apb_pwrite, 1'b1);
    check32("wr_c1_pwdata", bus.m_apb_pwdata, 32'hDEAD_BEEF);
    check1("wr_c1_cmd_ready", bus.cmd_ready, 1'b0);
    @(negedge clk);
    check1("wr_c2_psel", bus.m_apb_psel, 1'b1);
    check1("wr_c2_penable", bus.m_apb_penable, 1'b1);
    check1("wr_c2_rsp_valid", bus.rsp_valid, 1'b0);
    @(negedge clk);
    check1("wr_c3_rsp_valid", bus.rsp_valid, 1'b1);
    check1("wr_c3_psel", bus.m_apb_psel, 1'b0);
    check1("wr_c3_cmd_ready", bus.cmd_ready, 1'b0);
    @(negedge clk);
    check1("wr_c4_cmd_ready", bus.cmd_ready, 1'b1);
    check1("wr_c4_rsp_valid", bus.rsp_valid, 1'b0);
    check32("wr_c4_paddr_hold", bus.m_apb_paddr, 32'h0000_0010);
    drain();

    // Read with 3 wait states
    set_completer(3, 1'b0, 1'b0, 32'h1234_5678);
    expect_rsp(32'h1234_5678, 1'b0, 1'b0);
    issue(32'h0000_0004, 1'b0, 32'h0);
    run_access(32'h0000_0004, pen, stable, seen);
    check1("rd_wait_rsp_seen", seen, 1'b1);
    check32("rd_wait_penable_cycles", pen, 32'd4);
    check1("rd_wait_paddr_stable", stable, 1'b1);
    drain();

    // Read that ends in PSLVERR
    set_completer(1, 1'b0, 1'b1, 32'hA5A5_A5A5);
    expect_rsp(32'hA5A5_A5A5, 1'b1, 1'b0);
    issue(32'h0000_0008, 1'b0, 32'h0);
    run_access(32'h0000_0008, pen, stable, seen);
    check1("slverr_rsp_seen", seen, 1'b1);
    check32("slverr_penable_cycles", pen, 32'd2);
    drain();

    // Hung completer: abort after TO ACCESS cycles
    set_completer(0, 1'b1, 1'b0, 32'h7777_7777);
    expect_rsp(32'h0, 1'b1, 1'b1);
    issue(32'h0000_000C, 1'b0, 32'h0);
    run_access(32'h0000_000C, pen, stable, seen);
    check1("timeout_rsp_seen", seen, 1'b1);
    check32("timeout_penable_cycles", pen, 32'd8);
    check1("timeout_psel_dropped", bus.m_apb_psel, 1'b0);
    drain();

    // Response back-pressure: rsp_* stable and no accept for 5 cycles
    bus.rsp_ready = 1'b0;
    set_completer(0, 1'b0, 1'b1, 32'h0);
    expect_rsp(32'h0, 1'b1, 1'b0);
    issue(32'h0000_0020, 1'b1, 32'h5555_AAAA);
    run_access(32'h0000_0020, pen, stable, seen);
    check1("stall_rsp_seen", seen, 1'b1);
    stall_ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bus.rsp_valid !== 1'b1 || bus.cmd_ready !== 1'b0 || bus.rsp_rdata !== 32'h0 ||
          bus.rsp_slverr !== 1'b1 || bus.rsp_timeout !== 1'b0) stall_ok = 1'b0;
    end
    check1("stall_rsp_held", stall_ok, 1'b1);
    @(posedge clk);
    #1 bus.rsp_ready = 1'b1;
    drain();

    // Reset in the middle of ACCESS, then recover
    set_completer(5, 1'b0, 1'b0, 32'h9999_9999);
    issue(32'h0000_0040, 1'b0, 32'h0);
    @(negedge clk);
    @(negedge clk);
    check1("mid_access_penable", bus.m_apb_penable, 1'b1);
    #2 rst = 1'b1;
    #1;
    check1("areset_psel", bus.m_apb_psel, 1'b0);
    check1("areset_penable", bus.m_apb_penable, 1'b0);
    check1("areset_rsp_valid", bus.rsp_valid, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;

    set_completer(0, 1'b0, 1'b0, 32'h0);
    expect_rsp(32'h0, 1'b0, 1'b0);
    issue(32'h0000_0030, 1'b1, 32'h0BAD_F00D);
    run_access(32'h0000_0030, pen, stable, seen);
    check1("post_rst_wr_seen", seen, 1'b1);
    check32("post_rst_wr_penable", pen, 32'd1);
    drain();

    set_completer(2, 1'b0, 1'b0, 32'hCAFE_F00D);
    expect_rsp(32'hCAFE_F00D, 1'b0, 1'b0);
    issue(32'h0000_0034, 1'b0, 32'h0);
    run_access(32'h0000_0034, pen, stable, seen);
    check1("post_rst_rd_seen", seen, 1'b1);
    check32("post_rst_rd_penable", pen, 32'd3);
    check1("post_rst_rd_paddr_stable", stable, 1'b1);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
